muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the multi-cycle processor datapath, parametrised in operand width.
- Serves MUL and DIV opcodes. Adds high-half multiply, remainder, signed/unsigned mode and divide-by-zero reporting.
- Sits beside the single-cycle ALU. The control FSM issues requests over a valid/ready pair and stalls until the response handshake completes.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and width constants for the iterative multiply/divide unit.
// Included by the datapath top and its single-step sub-module.
package muldiv_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REGISTER_WIDTH = 5;

    typedef enum logic [1:0] {
        MUL_LO = 2'd0,
        MUL_HI = 2'd1,
        DIV    = 2'd2,
        REM    = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Purely combinational; the parent registers hi/lo between steps.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         is_div,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] operand,
    output logic [W-1:0] hi_next,
    output logic [W-1:0] lo_next
);

    logic [W:0] sum_s;
    logic [W:0] shifted_s;
    logic       ge_s;

    // hi:lo is the product for multiply and remainder:quotient for divide;
    // the remainder never exceeds the divisor, so W bits of hi suffice.
    always_comb begin
        sum_s     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(W+1){1'b0}});
        shifted_s = {hi, lo[W-1]};
        ge_s      = (shifted_s >= {1'b0, operand});
        if (is_div) begin
            if (ge_s) begin
                hi_next = W'(shifted_s - {1'b0, operand});
                lo_next = {lo[W-2:0], 1'b1};
            end else begin
                hi_next = shifted_s[W-1:0];
                lo_next = {lo[W-2:0], 1'b0};
            end
        end else begin
            hi_next = sum_s[W:1];
            lo_next = {sum_s[0], lo[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multi-cycle multiply/divide unit with valid/ready request and response.
// Operands are reduced to magnitudes on entry; signs are restored in the FIX cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = muldiv_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = muldiv_pkg::REGISTER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_div_by_zero,
    output logic                  busy
);
    import muldiv_pkg::*;

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    muldiv_state_t        state_r;
    logic [CW-1:0]        cnt_r;
    muldiv_op_t           op_r;
    logic                 neg_res_r;
    logic                 neg_rem_r;
    logic [TAG_WIDTH-1:0] tag_r;
    logic [W-1:0]         opnd_r;
    logic [W-1:0]         hi_r;
    logic [W-1:0]         lo_r;
    logic [W-1:0]         result_r;
    logic [TAG_WIDTH-1:0] resp_tag_r;
    logic                 dbz_r;

    muldiv_op_t           req_op_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [W-1:0]         a_mag_s;
    logic [W-1:0]         b_mag_s;
    logic                 dbz_s;
    logic                 ovf_s;
    logic [W-1:0]         early_res_s;
    logic [W-1:0]         hi_next_s;
    logic [W-1:0]         lo_next_s;
    logic [2*W-1:0]       prod_fix_s;
    logic [W-1:0]         quo_fix_s;
    logic [W-1:0]         rem_fix_s;
    logic [W-1:0]         fix_res_s;

    // Request decode: magnitudes, and the two cases that bypass iteration.
    always_comb begin
        req_op_s = muldiv_op_t'(req_op);
        a_neg_s  = req_signed & req_a[W-1];
        b_neg_s  = req_signed & req_b[W-1];
        a_mag_s  = a_neg_s ? ({W{1'b0}} - req_a) : req_a;
        b_mag_s  = b_neg_s ? ({W{1'b0}} - req_b) : req_b;
        dbz_s    = is_div_op(req_op_s) && (req_b == {W{1'b0}});
        ovf_s    = is_div_op(req_op_s) && req_signed &&
                   (req_a == {1'b1, {(W-1){1'b0}}}) && (req_b == {W{1'b1}});
        if (dbz_s) begin
            early_res_s = (req_op_s == REM) ? req_a : {W{1'b1}};
        end else begin
            early_res_s = (req_op_s == REM) ? {W{1'b0}} : req_a;
        end
    end

    muldiv_step #(
        .W(W)
    ) u_step (
        .is_div  (is_div_op(op_r)),
        .hi      (hi_r),
        .lo      (lo_r),
        .operand (opnd_r),
        .hi_next (hi_next_s),
        .lo_next (lo_next_s)
    );

    // Sign correction and result selection for the FIX cycle.
    always_comb begin
        prod_fix_s = neg_res_r ? ({(2*W){1'b0}} - {hi_r, lo_r}) : {hi_r, lo_r};
        quo_fix_s  = neg_res_r ? ({W{1'b0}} - lo_r) : lo_r;
        rem_fix_s  = neg_rem_r ? ({W{1'b0}} - hi_r) : hi_r;
        case (op_r)
            MUL_LO:  fix_res_s = prod_fix_s[W-1:0];
            MUL_HI:  fix_res_s = prod_fix_s[2*W-1:W];
            DIV:     fix_res_s = quo_fix_s;
            REM:     fix_res_s = rem_fix_s;
            default: fix_res_s = {W{1'b0}};
        endcase
    end

    // Control FSM, iteration datapath and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            op_r       <= MUL_LO;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            tag_r      <= {TAG_WIDTH{1'b0}};
            opnd_r     <= {W{1'b0}};
            hi_r       <= {W{1'b0}};
            lo_r       <= {W{1'b0}};
            result_r   <= {W{1'b0}};
            resp_tag_r <= {TAG_WIDTH{1'b0}};
            dbz_r      <= 1'b0;
        end else if (flush) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        op_r      <= req_op_s;
                        tag_r     <= req_tag;
                        neg_res_r <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        cnt_r     <= {CW{1'b0}};
                        if (dbz_s || ovf_s) begin
                            result_r   <= early_res_s;
                            resp_tag_r <= req_tag;
                            dbz_r      <= dbz_s;
                            state_r    <= DONE;
                        end else begin
                            hi_r    <= {W{1'b0}};
                            lo_r    <= is_div_op(req_op_s) ? a_mag_s : b_mag_s;
                            opnd_r  <= is_div_op(req_op_s) ? b_mag_s : a_mag_s;
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    hi_r <= hi_next_s;
                    lo_r <= lo_next_s;
                    if (cnt_r == CW'(W - 1)) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= FIX;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                FIX: begin
                    result_r   <= fix_res_s;
                    resp_tag_r <= tag_r;
                    dbz_r      <= 1'b0;
                    state_r    <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign req_ready        = (state_r == IDLE);
    assign busy             = (state_r != IDLE);
    assign resp_valid       = (state_r == DONE);
    assign resp_result      = result_r;
    assign resp_tag         = resp_tag_r;
    assign resp_div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: W=32 main instance plus a W=8 instance
// for the most-negative squared corner.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        req_valid, req_ready, req_signed;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic        resp_valid, resp_ready, resp_div_by_zero, busy;
    logic [31:0] resp_result;
    logic [4:0]  resp_tag;

    logic        v8, rdy8, s8, rv8, rr8, dbz8, busy8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, res8;
    logic [4:0]  tag8, rtag8;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_signed(req_signed), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_tag(resp_tag), .resp_div_by_zero(resp_div_by_zero), .busy(busy)
    );

    muldiv_unit #(.DATA_WIDTH(8), .TAG_WIDTH(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(v8), .req_ready(rdy8), .req_op(op8),
        .req_signed(s8), .req_a(a8), .req_b(b8), .req_tag(tag8),
        .resp_valid(rv8), .resp_ready(rr8), .resp_result(res8),
        .resp_tag(rtag8), .resp_div_by_zero(dbz8), .busy(busy8)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model with plain 64-bit arithmetic (SV / and % truncate toward zero).
    function automatic logic [31:0] model(input logic [1:0] op, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          output logic dbz);
        logic signed [63:0] sa, sb, r;
        dbz = 1'b0;
        if (op >= 2'd2 && b == 32'd0) begin
            dbz = 1'b1;
            return (op == 2'd3) ? a : 32'hFFFF_FFFF;
        end
        if (op >= 2'd2 && sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (op == 2'd3) ? 32'd0 : a;
        sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        case (op)
            2'd0:    r = sa * sb;
            2'd1:    r = (sa * sb) >>> 32;
            2'd2:    r = sa / sb;
            default: r = sa % sb;
        endcase
        return r[31:0];
    endfunction

    task automatic drive_raw(input logic [1:0] op, input logic sgn,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        chk_eq("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        req_op = op; req_signed = sgn; req_a = a; req_b = b; req_tag = tag;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        exp_t e;
        logic d;
        e.res = model(op, sgn, a, b, d);
        e.tag = tag;
        e.dbz = d;
        sb_q.push_back(e);
        drive_raw(op, sgn, a, b, tag);
    endtask

    // Called at #1 after the acceptance edge; lat counts further edges until resp_valid.
    task automatic collect(input int exp_lat, input int hold);
        int   lat = 0;
        exp_t e;
        while (!resp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_eq("latency", 64'(lat), 64'(exp_lat));
        e = sb_q.pop_front();
        chk_eq("result", {32'd0, resp_result}, {32'd0, e.res});
        chk_eq("tag", {59'd0, resp_tag}, {59'd0, e.tag});
        chk_eq("div_by_zero", {63'd0, resp_div_by_zero}, {63'd0, e.dbz});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk_eq("backpressure_hold", {25'd0, resp_valid, req_ready, resp_tag, resp_result},
                   {25'd0, 1'b1, 1'b0, e.tag, e.res});
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk_eq("idle_after_handshake", {61'd0, resp_valid, req_ready, busy}, 64'd2);
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] exp);
        int lat = 0;
        @(negedge clk);
        op8 = op; s8 = 1'b1; a8 = 8'h80; b8 = 8'h80; tag8 = 5'd3; v8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        while (!rv8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_eq("w8_latency", 64'(lat), 64'd9);
        chk_eq("w8_result", {56'd0, res8}, {56'd0, exp});
        rr8 = 1'b1;
        @(posedge clk);
        #1 rr8 = 1'b0;
    endtask

    initial begin
        logic [1:0]  op;
        logic        sgn, seen;
        logic [31:0] a, b;
        int          el;

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 2'd0; req_signed = 1'b0; req_a = 32'd0; req_b = 32'd0; req_tag = 5'd0;
        v8 = 1'b0; rr8 = 1'b0; op8 = 2'd0; s8 = 1'b0; a8 = 8'd0; b8 = 8'd0; tag8 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("reset_state", {23'd0, req_ready, busy, resp_valid, resp_div_by_zero, resp_tag, resp_result},
               {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
        rst_n = 1'b1;

        issue(2'd0, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd7); collect(33, 0);
        issue(2'd1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd7); collect(33, 0);
        issue(2'd2, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd1);         collect(33, 10);
        issue(2'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd2);         collect(33, 0);
        issue(2'd2, 1'b0, 32'd100, 32'd7, 5'd4);               collect(33, 0);
        issue(2'd3, 1'b0, 32'd100, 32'd7, 5'd5);               collect(33, 0);
        issue(2'd2, 1'b0, 32'h1234, 32'd0, 5'd6);              collect(0, 0);
        issue(2'd3, 1'b0, 32'h1234, 32'd0, 5'd8);              collect(0, 0);
        issue(2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9); collect(0, 0);
        issue(2'd1, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd10); collect(33, 0);
        issue(2'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd11); collect(33, 0);
        issue(2'd3, 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd12);        collect(33, 0);

        for (int i = 0; i < 16; i++) begin
            op  = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = (i % 4 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 1) a = 32'($urandom_range(0, 1000));
            el  = (op >= 2'd2 && (b == 32'd0 ||
                  (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 33;
            issue(op, sgn, a, b, 5'(i));
            collect(el, 0);
        end

        // Flush while the counter is at 10.
        drive_raw(2'd0, 1'b0, 32'd123, 32'd456, 5'd13);
        repeat (10) @(posedge clk);
        #1;
        chk_eq("busy_in_calc", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk_eq("flush_to_idle", {61'd0, busy, resp_valid, req_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk_eq("no_resp_after_flush", {63'd0, seen}, 64'd0);
        issue(2'd0, 1'b0, 32'd3, 32'd5, 5'd14); collect(33, 0);

        // Reset mid-CALC.
        drive_raw(2'd1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("reset_mid_calc", {23'd0, req_ready, busy, resp_valid, resp_div_by_zero, resp_tag, resp_result},
               {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk_eq("no_resp_after_reset", {63'd0, seen}, 64'd0);

        run8(2'd1, 8'h40);
        run8(2'd0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
